muldiv_unit: RTL

//   Iterative 32x32 multiply / 32/32 divide unit in the EX stage, beside the ALU, fed from the same ID/EX operand buses.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU.
// MULT/MULTU use shift-add over the operand magnitudes; DIV/DIVU use a
// restoring divider. Signs are applied in a single FIX cycle before HI/LO
// are written.
// Optional feature: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC
// as soon as the remaining multiplier bits are all zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;   // product, or remainder in the low bits
    logic [W2-1:0]    mcd_q, mcd_d;   // shifting multiplicand, or dividend/quotient
    logic [WIDTH-1:0] mpl_q, mpl_d;   // shifting multiplier, or divisor
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;   // product / quotient sign
    logic             negr_q, negr_d; // remainder sign (follows dividend)
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, divz_q, divz_d;

    // Operand conditioning at issue: magnitudes for signed ops, raw otherwise
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = ~op[0];
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One restoring-division step: shift next dividend bit in, try subtract
    logic [WIDTH:0] rem_sh, diff;
    assign rem_sh = {acc_q[WIDTH-1:0], mcd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, mpl_q};

    logic early_done;
`ifdef MULDIV_EARLY_OUT_EN
    assign early_done = ((mpl_q >> 1) == '0);
`else
    assign early_done = 1'b0;
`endif

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = divz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state, datapath step and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcd_d    = mcd_q;
        mpl_d    = mpl_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        divz_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mthi) hi_d = a;
                if (mtlo) lo_d = a;
                if (start && !cancel) begin
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    negr_d   = a_neg;
                    dz_d     = op[1] && (b == '0);
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcd_d    = {{WIDTH{1'b0}}, a_mag};
                    mpl_d    = b_mag;
                    state_d  = S_CALC;
                    if (op[1] && (b == '0)) begin
                        // HI must receive the raw dividend, not its magnitude
                        mcd_d   = {{WIDTH{1'b0}}, a};
                        state_d = S_FIX;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    else if (!op[1] && (b_mag == '0)) begin
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!is_div_q) begin
                        if (mpl_q[0]) acc_d = acc_q + mcd_q;
                        mcd_d = mcd_q << 1;
                        mpl_d = mpl_q >> 1;
                        if (early_done) state_d = S_FIX;
                    end else begin
                        acc_d = diff[WIDTH] ? {{(WIDTH-1){1'b0}}, rem_sh}
                                            : {{(WIDTH-1){1'b0}}, diff};
                        mcd_d = {{WIDTH{1'b0}}, mcd_q[WIDTH-2:0], ~diff[WIDTH]};
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        hi_d   = mcd_q[WIDTH-1:0];
                        lo_d   = '1;
                        divz_d = 1'b1;
                    end else if (is_div_q) begin
                        lo_d = neg_q  ? -mcd_q[WIDTH-1:0] : mcd_q[WIDTH-1:0];
                        hi_d = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    end else begin
                        {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcd_q    <= '0;
            mpl_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcd_q    <= mcd_d;
            mpl_q    <= mpl_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            divz_q   <= divz_d;
        end
    end
endmodule
